bm_mem_arb: RTL and testbench

Round-robin arbiter that shares the single read port of the bitmatrix memory between up to N_REQ bitmatrix column controllers, one per engine. It grants one read per cycle and drives the memory address and enable from registers. It tracks each in-flight read's owner through a fixed-latency tag pipeline and routes returned column data back to the owner with a one-hot valid. Per-requester flush discards that requester's in-flight reads when its engine is reset mid-calculation.

---
 rtl/bm_mem_arb.sv | 95 +++++++++
 tb/tb_bm_mem_arb.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bm_mem_arb.sv
// bm_mem_arb: round-robin arbiter sharing the bitmatrix memory read port; a fixed-latency
// tag pipeline routes returned column data to the requester that issued the read.
module bm_mem_arb #(
    parameter int N_REQ = 4,
    parameter int BM_MEM_ADDR_W = 8,
    parameter int BM_COL_W = 256,
    parameter int RD_LAT = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           arb_en,
    input  logic [N_REQ-1:0]               req_rd_rq,
    input  logic [N_REQ*BM_MEM_ADDR_W-1:0] req_rd_addr,
    input  logic [N_REQ-1:0]               req_flush,
    output logic [N_REQ-1:0]               req_rd_gnt,
    output logic [BM_COL_W-1:0]            req_rd_data,
    output logic [N_REQ-1:0]               req_rd_data_val,
    output logic                           mem_rd_en,
    output logic [BM_MEM_ADDR_W-1:0]       mem_rd_addr,
    input  logic [BM_COL_W-1:0]            mem_rd_data,
    input  logic                           mem_rd_data_val,
    output logic                           arb_busy,
    output logic                           lat_err
);
    localparam int IW = $clog2(N_REQ);
    logic [N_REQ-1:0] eff_rq, data_val_q;
    logic [IW-1:0] ptr_q, gnt_id;
    logic [IW:0] cand;
    logic gnt_v, en_q, err_q, hit;
    logic [BM_MEM_ADDR_W-1:0] gnt_addr, addr_q;
    logic [BM_COL_W-1:0] data_q;
    logic [RD_LAT:0] v_q, v_eff, raw_q;
    logic [RD_LAT:0][IW-1:0] id_q;

    assign eff_rq = req_rd_rq & ~req_flush & {N_REQ{arb_en}};

    // Scan farthest-first so the candidate nearest to ptr is the last (winning) assignment.
    always_comb begin
        gnt_v = 1'b0;
        gnt_id = '0;
        cand = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr_q} + (IW+1)'(k);
            cand = (cand >= (IW+1)'(N_REQ)) ? cand - (IW+1)'(N_REQ) : cand;
            if (eff_rq[cand[IW-1:0]]) begin
                gnt_v = 1'b1;
                gnt_id = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        gnt_addr = '0;
        v_eff = '0;
        for (int i = 0; i < N_REQ; i++)
            if (gnt_id == IW'(i)) gnt_addr = req_rd_addr[i*BM_MEM_ADDR_W +: BM_MEM_ADDR_W];
        for (int k = 0; k <= RD_LAT; k++) v_eff[k] = v_q[k] & ~req_flush[id_q[k]];
    end

    assign hit = v_eff[RD_LAT] & mem_rd_data_val;
    assign req_rd_gnt = (gnt_v && !rst) ? N_REQ'(1) << gnt_id : '0;
    assign req_rd_data = data_q;
    assign req_rd_data_val = data_val_q;
    assign mem_rd_en = en_q;
    assign mem_rd_addr = addr_q;
    assign arb_busy = en_q | (|v_q);
    assign lat_err = err_q;

    // raw_q tracks issued reads without flush clearing so latency checking ignores flushes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
            en_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            data_val_q <= '0;
            v_q <= '0;
            raw_q <= '0;
            id_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (gnt_v) begin
                ptr_q <= (gnt_id == IW'(N_REQ - 1)) ? '0 : gnt_id + IW'(1);
                addr_q <= gnt_addr;
            end
            en_q <= gnt_v;
            v_q <= {v_eff[RD_LAT-1:0], gnt_v};
            raw_q <= {raw_q[RD_LAT-1:0], gnt_v};
            id_q <= {id_q[RD_LAT-1:0], gnt_id};
            data_val_q <= hit ? N_REQ'(1) << id_q[RD_LAT] : '0;
            if (hit) data_q <= mem_rd_data;
            if (mem_rd_data_val != raw_q[RD_LAT]) err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_bm_mem_arb.sv
// tb_bm_mem_arb: bench for bm_mem_arb with a fixed-latency memory model; each grant
// pushes its expected return, which is popped when the return is due.
module tb_bm_mem_arb;
    localparam int N = 4, AW = 8, CW = 256, LAT = 1;
    logic clk = 0, rst = 1, arb_en = 1, mval = 0, men, busy, lerr;
    logic [N-1:0] rq = '0, flush = '0, gnt, dval, ev;
    logic [N*AW-1:0] addr = {8'h43, 8'h42, 8'h41, 8'h40};
    logic [CW-1:0] rdata, mdata = '0;
    logic [AW-1:0] maddr;
    int checks = 0, failures = 0, cyc = 0;
    bit sb_on = 1, lat_x = 0;
    typedef struct { int id; logic [CW-1:0] data; int due; } ent_t;
    ent_t sb[$];
    bit en_p [LAT+2];
    logic [AW-1:0] ad_p [LAT+2];
    int cnt [N];

    bm_mem_arb #(.N_REQ(N), .BM_MEM_ADDR_W(AW), .BM_COL_W(CW), .RD_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .arb_en(arb_en), .req_rd_rq(rq), .req_rd_addr(addr),
        .req_flush(flush), .req_rd_gnt(gnt), .req_rd_data(rdata), .req_rd_data_val(dval),
        .mem_rd_en(men), .mem_rd_addr(maddr), .mem_rd_data(mdata), .mem_rd_data_val(mval),
        .arb_busy(busy), .lat_err(lerr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [CW-1:0] mk_data(input logic [AW-1:0] a);
        return {32{a}} ^ {32{8'hA5}};
    endfunction

    // Memory: returns data LAT cycles after mem_rd_en (LAT+1 when lat_x injects a fault).
    always @(negedge clk) begin
        if (rst) begin
            foreach (en_p[k]) en_p[k] = 1'b0;
            mval = 1'b0;
            mdata = '0;
        end else begin
            for (int k = LAT + 1; k > 0; k--) begin
                en_p[k] = en_p[k-1];
                ad_p[k] = ad_p[k-1];
            end
            en_p[0] = men;
            ad_p[0] = maddr;
            mval = en_p[lat_x ? LAT + 1 : LAT];
            mdata = mval ? mk_data(ad_p[lat_x ? LAT + 1 : LAT]) : '0;
        end
    end

    always @(negedge clk) begin
        if (!rst && sb_on) begin
            for (int k = sb.size() - 1; k >= 0; k--)
                if (flush[sb[k].id] && cyc >= sb[k].due - 1 - LAT && cyc <= sb[k].due - 1) sb.delete(k);
            ev = (sb.size() > 0 && sb[0].due == cyc) ? N'(1) << sb[0].id : '0;
            checks++;
            if (dval !== ev) begin
                failures++;
                $display("FAIL sb_data_val cyc=%0d got=%b exp=%b", cyc, dval, ev);
            end
            if (ev != '0) begin
                checks++;
                if (rdata !== sb[0].data) begin
                    failures++;
                    $display("FAIL sb_data cyc=%0d got=%h exp=%h", cyc, rdata, sb[0].data);
                end
                void'(sb.pop_front());
            end
            for (int i = 0; i < N; i++)
                if (gnt[i]) sb.push_back('{i, mk_data(addr[i*AW +: AW]), cyc + 2 + LAT});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rq = 4'b1111;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0) begin failures++; $display("FAIL rst_gnt got=%b exp=0000", gnt); end
        checks++;
        if ({men, maddr, dval, busy, lerr} !== '0) begin
            failures++;
            $display("FAIL rst_outs got en=%b addr=%h val=%b busy=%b err=%b exp all 0", men, maddr, dval, busy, lerr);
        end
        checks++;
        if (rdata !== '0) begin failures++; $display("FAIL rst_data got=%h exp=0", rdata); end
        @(posedge clk);
        #1;
        rst = 0;
        rq = '0;
    endtask

    task automatic test_single();
        addr[2*AW +: AW] = 8'h15;
        rq = 4'b0100;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0100) begin failures++; $display("FAIL single_gnt got=%b exp=0100", gnt); end
        step();
        rq = '0;
        @(negedge clk);
        checks++;
        if ({men, maddr, busy} !== {1'b1, 8'h15, 1'b1}) begin
            failures++;
            $display("FAIL single_mem got en=%b addr=%h busy=%b exp en=1 addr=15 busy=1", men, maddr, busy);
        end
        step();
        step();
        @(negedge clk);
        checks++;
        if (dval !== 4'b0100 || rdata !== mk_data(8'h15)) begin
            failures++;
            $display("FAIL single_ret got val=%b data=%h exp val=0100 data=%h", dval, rdata, mk_data(8'h15));
        end
        step();
    endtask

    task automatic test_rotation();
        logic [N-1:0] rqs [4] = '{4'b1000, 4'b1010, 4'b1010, 4'b1010};
        logic [N-1:0] exp [4] = '{4'b1000, 4'b0010, 4'b1000, 4'b0010};
        for (int k = 0; k < 4; k++) begin
            rq = rqs[k];
            @(negedge clk);
            checks++;
            if (gnt !== exp[k]) begin failures++; $display("FAIL rot_gnt%0d got=%b exp=%b", k, gnt, exp[k]); end
            step();
        end
        rq = '0;
        repeat (4) step();
    endtask

    task automatic test_fairness();
        foreach (cnt[i]) cnt[i] = 0;
        rq = 4'b1111;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            checks++;
            if (gnt !== N'(1) << ((2 + k) % N)) begin
                failures++;
                $display("FAIL fair_gnt%0d got=%b exp=%b", k, gnt, N'(1) << ((2 + k) % N));
            end
            for (int i = 0; i < N; i++) if (gnt[i]) cnt[i]++;
            step();
        end
        rq = '0;
        for (int i = 0; i < N; i++) begin
            checks++;
            if (cnt[i] != 10) begin failures++; $display("FAIL fair_cnt%0d got=%0d exp=10", i, cnt[i]); end
        end
        repeat (4) step();
    endtask

    task automatic test_flush();
        rq = 4'b0010;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0010) begin failures++; $display("FAIL flush_gnt1 got=%b exp=0010", gnt); end
        step();
        rq = 4'b0001;
        flush = 4'b0010;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0001) begin failures++; $display("FAIL flush_gnt0 got=%b exp=0001", gnt); end
        step();
        rq = 4'b0011;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0001) begin failures++; $display("FAIL flush_same_cycle got=%b exp=0001", gnt); end
        step();
        rq = '0;
        flush = '0;
        @(negedge clk);
        checks++;
        if (dval !== 4'b0000 || lerr !== 1'b0) begin
            failures++;
            $display("FAIL flush_drop got val=%b err=%b exp val=0000 err=0", dval, lerr);
        end
        step();
        @(negedge clk);
        checks++;
        if (dval !== 4'b0001) begin failures++; $display("FAIL flush_other got=%b exp=0001", dval); end
        repeat (4) step();
    endtask

    task automatic test_arb_en();
        arb_en = 0;
        rq = 4'b1111;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0) begin failures++; $display("FAIL en_off_gnt got=%b exp=0000", gnt); end
        step();
        arb_en = 1;
        @(negedge clk);
        checks++;
        if (men !== 1'b0 || busy !== 1'b0 || gnt !== 4'b0010) begin
            failures++;
            $display("FAIL en_on got en=%b busy=%b gnt=%b exp en=0 busy=0 gnt=0010", men, busy, gnt);
        end
        step();
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0100) begin failures++; $display("FAIL en_gnt2 got=%b exp=0100", gnt); end
        step();
        arb_en = 0;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0 || men !== 1'b1) begin
            failures++;
            $display("FAIL en_fall got gnt=%b en=%b exp gnt=0000 en=1", gnt, men);
        end
        step();
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || men !== 1'b0) begin
            failures++;
            $display("FAIL en_busy got busy=%b en=%b exp busy=1 en=0", busy, men);
        end
        step();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || dval !== 4'b0100) begin
            failures++;
            $display("FAIL en_idle got busy=%b val=%b exp busy=0 val=0100", busy, dval);
        end
        rq = '0;
        arb_en = 1;
        repeat (3) step();
    endtask

    task automatic test_lat_fault();
        sb_on = 0;
        sb.delete();
        lat_x = 1;
        rq = 4'b0001;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0001) begin failures++; $display("FAIL lat_gnt got=%b exp=0001", gnt); end
        step();
        rq = '0;
        step();
        step();
        @(negedge clk);
        checks++;
        if (lerr !== 1'b1 || dval !== 4'b0) begin
            failures++;
            $display("FAIL lat_err got err=%b val=%b exp err=1 val=0000", lerr, dval);
        end
        lat_x = 0;
        repeat (4) step();
        @(negedge clk);
        checks++;
        if (lerr !== 1'b1) begin failures++; $display("FAIL lat_sticky got=%b exp=1", lerr); end
        step();
    endtask

    task automatic test_async_rst();
        rq = 4'b1111;
        repeat (3) step();
        #2;
        rst = 1;
        #1;
        checks++;
        if ({gnt, men, maddr, dval, busy, lerr} !== '0 || rdata !== '0) begin
            failures++;
            $display("FAIL async_rst got gnt=%b en=%b addr=%h val=%b busy=%b err=%b data=%h exp all 0",
                     gnt, men, maddr, dval, busy, lerr, rdata);
        end
        rq = '0;
        step();
        rst = 0;
        sb.delete();
        sb_on = 1;
        rq = 4'b1010;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0010) begin failures++; $display("FAIL rst_ptr got=%b exp=0010", gnt); end
        step();
        rq = '0;
        repeat (5) step();
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL sb_drain got=%0d pending exp=0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_fairness();
        test_flush();
        test_arb_en();
        test_lat_fault();
        test_async_rst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
